h264enc_frame_seq: RTL and testbench
====================================

// Module: h264enc_frame_seq
// PURPOSE
//  Frame-level sequencer in the enc_clk domain between the register/AXI interface and
//  the encoder core. Kicks one encoder run per frame and issues macroblock load
//  requests (x,y) in raster order to the pixel loader. A credit counter bounds how many
//  MBs the loader may run ahead of the encoder. Signals frame completion and protocol errors.
// PARAMETERS
//  XW         8   width of MB column index / x_total
//  YW         8   width of MB row index / y_total
//  MAX_AHEAD  2   max MBs loaded but not yet consumed by encoder (1..7)
//  FCW        16  width of frame counter
// PORTS
//  enc_clk       in   1       encoder clock
//  enc_rstn      in   1       async active-low reset
//  start_i       in   1       frame start request, 1-cycle pulse
//  x_total_i     in   XW      last MB column index (MB columns - 1)
//  y_total_i     in   YW      last MB row index (MB rows - 1)
//  sys_start_o   out  1       encoder run kick, 1-cycle pulse
//  sys_done_i    in   1       encoder frame finished, 1-cycle pulse
//  mb_ld_o       out  1       MB load request, 1-cycle pulse
//  x_ld_o        out  XW      MB column of current/last request
//  y_ld_o        out  YW      MB row of current/last request
//  ld_ack_i      in   1       loader finished the requested MB, 1-cycle pulse
//  mb_done_i     in   1       encoder consumed one loaded MB, 1-cycle pulse
//  busy_o        out  1       1 in any state other than IDLE
//  frame_done_o  out  1       frame end, 1-cycle pulse
//  frame_cnt_o   out  FCW     frames completed, wraps at 2^FCW
//  err_o         out  1       sticky protocol error
// BEHAVIOUR
//  Reset: enc_rstn low -> clock and reset per the already-decided line: reset enc_rstn,
//   asynchronous, active-low; clock enc_clk. All outputs 0, state IDLE, credit 0,
//   totals 0. A reset mid-frame abandons the frame and produces no frame_done_o.
//  FSM states: IDLE, KICK, LOAD, WAIT_ACK, DRAIN.
//  IDLE: on start_i -> latch x_total_i/y_total_i, x=y=0, credit=0, err_o cleared -> KICK.
//  KICK: sys_start_o=1 for exactly one cycle -> LOAD.
//  LOAD: if credit<MAX_AHEAD -> mb_ld_o=1 for one cycle with x_ld_o/y_ld_o=x,y -> WAIT_ACK;
//   else stay in LOAD with mb_ld_o=0.
//  WAIT_ACK: on ld_ack_i -> credit+1. If x==xt && y==yt -> DRAIN. Else advance:
//   x==xt ? (x=0, y=y+1) : x=x+1 -> LOAD. ld_ack_i in any other state is ignored and
//   sets err_o.
//  DRAIN: on sys_done_i -> frame_done_o=1 for one cycle, frame_cnt_o+1 -> IDLE.
//  Min spacing between consecutive mb_ld_o pulses: 3 cycles, with ack in the cycle
//   after the request.
//  Credit counter: width clog2(MAX_AHEAD+1). ld_ack_i and mb_done_i in the same cycle
//   leave it unchanged. mb_done_i with credit==0 leaves it at 0 and sets err_o.
//   Credit is never reset between MBs, only at frame start.
//  x_ld_o/y_ld_o: registered and held between requests. They reset to 0 at frame start.
//  start_i when not in IDLE: ignored, sets err_o.
//  sys_done_i in KICK/LOAD/WAIT_ACK (early done): sets err_o, frame_done_o pulses,
//   frame_cnt_o unchanged -> IDLE.
//  sys_done_i in IDLE: ignored, sets err_o.
//  1x1 frame (xt=yt=0): exactly one mb_ld_o at (0,0), then DRAIN.
//  err_o: sticky until the next accepted start_i.
// TESTING
//  xt=1,yt=1, acks 1 cycle after each req, mb_done_i after each ack, sys_done_i after the
//   4th ack -> mb_ld at (0,0),(1,0),(0,1),(1,1), one frame_done_o, frame_cnt_o=1, err_o=0.
//  MAX_AHEAD=2, xt=3,yt=0, no mb_done_i -> exactly 2 requests, FSM holds in LOAD; one
//   mb_done_i -> 3rd request at (2,0).
//  ld_ack_i and mb_done_i in the same cycle with credit=1 -> credit stays 1, next req issued.
//  start_i pulse while busy -> err_o=1, frame continues; next valid start clears err_o.
//  sys_done_i after 2nd of 4 acks -> err_o=1, frame_done_o pulse, frame_cnt_o unchanged,
//   busy_o=0.
//  enc_rstn asserted in WAIT_ACK -> all outputs 0 at once; a fresh start runs a normal frame.

Source files
------------

// File: rtl/h264enc_frame_seq.sv
// Frame sequencer: kicks the encoder once per frame and streams raster-order
// MB load requests to the pixel loader, bounded by a run-ahead credit.
module h264enc_frame_seq #(
  parameter int XW        = 8,
  parameter int YW        = 8,
  parameter int MAX_AHEAD = 2,
  parameter int FCW       = 16
) (
  input  logic           enc_clk,
  input  logic           enc_rstn,
  input  logic           start_i,
  input  logic [XW-1:0]  x_total_i,
  input  logic [YW-1:0]  y_total_i,
  output logic           sys_start_o,
  input  logic           sys_done_i,
  output logic           mb_ld_o,
  output logic [XW-1:0]  x_ld_o,
  output logic [YW-1:0]  y_ld_o,
  input  logic           ld_ack_i,
  input  logic           mb_done_i,
  output logic           busy_o,
  output logic           frame_done_o,
  output logic [FCW-1:0] frame_cnt_o,
  output logic           err_o
);

  localparam int CW = $clog2(MAX_AHEAD + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] KICK     = 3'd1;
  localparam logic [2:0] LOAD     = 3'd2;
  localparam logic [2:0] WAIT_ACK = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;

  logic [2:0]    state;
  logic [XW-1:0] x;
  logic [XW-1:0] xt;
  logic [YW-1:0] y;
  logic [YW-1:0] yt;
  logic [CW-1:0] credit;

  logic start_acc;
  logic ack_ok;
  logic can_ld;
  logic last_mb;
  logic early_done;
  logic err_set;

  assign start_acc  = start_i && (state == IDLE);
  assign ack_ok     = ld_ack_i && (state == WAIT_ACK);
  assign can_ld     = credit < CW'(MAX_AHEAD);
  assign last_mb    = (x == xt) && (y == yt);
  assign early_done = sys_done_i &&
                      (state == KICK || state == LOAD ||
                       state == WAIT_ACK);
  assign busy_o     = state != IDLE;

  // Underflow only counts when no ack arrives in the same cycle.
  assign err_set = (start_i && state != IDLE) ||
                   (ld_ack_i && state != WAIT_ACK) ||
                   (sys_done_i && state != DRAIN) ||
                   (mb_done_i && !ack_ok && credit == '0);

  always_ff @(posedge enc_clk or negedge enc_rstn) begin
    if (!enc_rstn) begin
      credit <= '0;
    end else if (start_acc) begin
      credit <= '0;
    end else if (ack_ok && !mb_done_i) begin
      credit <= credit + CW'(1);
    end else if (!ack_ok && mb_done_i && credit != '0) begin
      credit <= credit - CW'(1);
    end
  end

  always_ff @(posedge enc_clk or negedge enc_rstn) begin
    if (!enc_rstn) begin
      err_o <= 1'b0;
    end else begin
      err_o <= err_set || (err_o && !start_acc);
    end
  end

  always_ff @(posedge enc_clk or negedge enc_rstn) begin
    if (!enc_rstn) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      xt           <= '0;
      yt           <= '0;
      x_ld_o       <= '0;
      y_ld_o       <= '0;
      sys_start_o  <= 1'b0;
      mb_ld_o      <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      sys_start_o  <= 1'b0;
      mb_ld_o      <= 1'b0;
      frame_done_o <= 1'b0;
      if (early_done) begin
        frame_done_o <= 1'b1;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            xt          <= x_total_i;
            yt          <= y_total_i;
            x           <= '0;
            y           <= '0;
            x_ld_o      <= '0;
            y_ld_o      <= '0;
            sys_start_o <= 1'b1;
            state       <= KICK;
          end
          KICK: state <= LOAD;
          LOAD: if (can_ld) begin
            mb_ld_o <= 1'b1;
            x_ld_o  <= x;
            y_ld_o  <= y;
            state   <= WAIT_ACK;
          end
          WAIT_ACK: if (ld_ack_i) begin
            if (last_mb) begin
              state <= DRAIN;
            end else begin
              if (x == xt) begin
                x <= '0;
                y <= y + YW'(1);
              end else begin
                x <= x + XW'(1);
              end
              state <= LOAD;
            end
          end
          DRAIN: if (sys_done_i) begin
            frame_done_o <= 1'b1;
            frame_cnt_o  <= frame_cnt_o + FCW'(1);
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_h264enc_frame_seq.sv
// Directed bench for h264enc_frame_seq with a queue of expected MB requests.
module tb_h264enc_frame_seq;

  logic        enc_clk = 1'b0;
  logic        enc_rstn;
  logic        start_i;
  logic [7:0]  x_total_i;
  logic [7:0]  y_total_i;
  logic        sys_start_o;
  logic        sys_done_i;
  logic        mb_ld_o;
  logic [7:0]  x_ld_o;
  logic [7:0]  y_ld_o;
  logic        ld_ack_i;
  logic        mb_done_i;
  logic        busy_o;
  logic        frame_done_o;
  logic [15:0] frame_cnt_o;
  logic        err_o;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } mb_t;

  mb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  h264enc_frame_seq #(
    .XW(8), .YW(8), .MAX_AHEAD(2), .FCW(16)
  ) dut (
    .enc_clk(enc_clk),
    .enc_rstn(enc_rstn),
    .start_i(start_i),
    .x_total_i(x_total_i),
    .y_total_i(y_total_i),
    .sys_start_o(sys_start_o),
    .sys_done_i(sys_done_i),
    .mb_ld_o(mb_ld_o),
    .x_ld_o(x_ld_o),
    .y_ld_o(y_ld_o),
    .ld_ack_i(ld_ack_i),
    .mb_done_i(mb_done_i),
    .busy_o(busy_o),
    .frame_done_o(frame_done_o),
    .frame_cnt_o(frame_cnt_o),
    .err_o(err_o)
  );

  always #5 enc_clk = ~enc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge enc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_mbs(input int xt, input int yt, input int n);
    int k;
    k = 0;
    for (int yy = 0; yy <= yt; yy++)
      for (int xx = 0; xx <= xt; xx++) begin
        if (k < n) exp_q.push_back('{x: 8'(xx), y: 8'(yy)});
        k++;
      end
  endtask

  task automatic start_frame(input int xt, input int yt);
    x_total_i = 8'(xt);
    y_total_i = 8'(yt);
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    check("sys_start", sys_start_o, 1);
    check("busy_kick", busy_o, 1);
  endtask

  task automatic wait_req(input string tag);
    mb_t e;
    bit  seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mb_ld_o) seen = 1;
      else tick();
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_extra"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_x"}, x_ld_o, e.x);
      check({tag, "_y"}, y_ld_o, e.y);
    end
  endtask

  task automatic do_ack(input bit with_done);
    ld_ack_i = 1'b1;
    tick();
    ld_ack_i = 1'b0;
    if (with_done) begin
      mb_done_i = 1'b1;
      tick();
      mb_done_i = 1'b0;
    end
  endtask

  task automatic count_reqs(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (mb_ld_o) n++;
    end
  endtask

  task automatic pulse_done();
    sys_done_i = 1'b1;
    tick();
    sys_done_i = 1'b0;
  endtask

  int n;

  initial begin
    enc_rstn   = 1'b0;
    start_i    = 1'b0;
    x_total_i  = '0;
    y_total_i  = '0;
    sys_done_i = 1'b0;
    ld_ack_i   = 1'b0;
    mb_done_i  = 1'b0;
    #12;
    check("rst_busy", busy_o, 0);
    check("rst_mb_ld", mb_ld_o, 0);
    check("rst_cnt", frame_cnt_o, 0);
    check("rst_err", err_o, 0);
    tick();
    enc_rstn = 1'b1;
    tick();

    // 2x2 frame with ack and consume after every MB
    push_mbs(1, 1, 4);
    start_frame(1, 1);
    for (int i = 0; i < 4; i++) begin
      wait_req("f1_req");
      do_ack(1);
    end
    count_reqs(3, n);
    check("f1_no_extra", n, 0);
    check("f1_busy_drain", busy_o, 1);
    pulse_done();
    check("f1_done", frame_done_o, 1);
    check("f1_cnt", frame_cnt_o, 1);
    check("f1_err", err_o, 0);
    check("f1_idle", busy_o, 0);
    tick();
    check("f1_done_pulse", frame_done_o, 0);

    // credit limit: 4x1 frame, no consumption
    push_mbs(3, 0, 4);
    start_frame(3, 0);
    wait_req("f2_req0");
    do_ack(0);
    wait_req("f2_req1");
    do_ack(0);
    count_reqs(6, n);
    check("f2_hold", n, 0);
    check("f2_hold_busy", busy_o, 1);
    mb_done_i = 1'b1;
    tick();
    mb_done_i = 1'b0;
    wait_req("f2_req2");
    ld_ack_i  = 1'b1;
    mb_done_i = 1'b1;
    tick();
    ld_ack_i  = 1'b0;
    mb_done_i = 1'b0;
    wait_req("f2_req3");
    start_i   = 1'b1;
    x_total_i = '0;
    tick();
    start_i   = 1'b0;
    check("f2_err_start", err_o, 1);
    check("f2_busy_start", busy_o, 1);
    do_ack(0);
    count_reqs(3, n);
    check("f2_no_extra", n, 0);
    pulse_done();
    check("f2_done", frame_done_o, 1);
    check("f2_cnt", frame_cnt_o, 2);
    check("f2_err_sticky", err_o, 1);
    check("f2_qempty", exp_q.size(), 0);

    // early sys_done after the second of four acks
    push_mbs(1, 1, 2);
    start_frame(1, 1);
    check("f3_err_clr", err_o, 0);
    wait_req("f3_req");
    do_ack(1);
    wait_req("f3_req");
    do_ack(0);
    pulse_done();
    check("f3_done", frame_done_o, 1);
    check("f3_cnt", frame_cnt_o, 2);
    check("f3_err", err_o, 1);
    check("f3_busy", busy_o, 0);
    count_reqs(3, n);
    check("f3_no_req", n, 0);
    check("f3_qempty", exp_q.size(), 0);

    // reset while waiting for an ack
    push_mbs(1, 0, 1);
    start_frame(1, 0);
    wait_req("f4_req");
    enc_rstn = 1'b0;
    #1;
    check("f4_rst_mb_ld", mb_ld_o, 0);
    check("f4_rst_busy", busy_o, 0);
    check("f4_rst_cnt", frame_cnt_o, 0);
    check("f4_rst_x", x_ld_o, 0);
    check("f4_rst_err", err_o, 0);
    tick();
    enc_rstn = 1'b1;
    tick();

    // fresh 1x1 frame after reset
    push_mbs(0, 0, 1);
    start_frame(0, 0);
    wait_req("f5_req");
    do_ack(1);
    count_reqs(4, n);
    check("f5_single", n, 0);
    check("f5_busy", busy_o, 1);
    pulse_done();
    check("f5_done", frame_done_o, 1);
    check("f5_cnt", frame_cnt_o, 1);
    check("f5_err", err_o, 0);
    check("f5_idle", busy_o, 0);
    check("f5_qempty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
